mult_accumulator: RTL and testbench

- Downstream consumer of the `multiplier` block: takes its registered product stream and sums a programmed number of products into one result (dot-product / MAC tail).
- Valid/ready handshake on both sides.
- Signed or unsigned accumulation, matching the upstream multiplier's mode.
- Saturating accumulator with a sticky overflow flag; one result per job.

---
 rtl/mult_accumulator.sv | 119 +++++++++++
 tb/tb_mult_accumulator.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_accumulator.sv
// mult_accumulator: sums a programmed number of products from the upstream
// multiplier into one saturating result per job. Valid/ready on both sides,
// sticky per-job saturation flag, signed or unsigned per SIGNED_MULT.
module mult_accumulator #(
  parameter int DATA_WIDTH  = 8,
  parameter int SIGNED_MULT = 0,
  parameter int ACC_WIDTH   = 2*DATA_WIDTH+8,
  parameter int MAX_LEN     = 256,
  localparam int CNT_W      = $clog2(MAX_LEN+1),
  localparam int P_W        = 2*DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CNT_W-1:0]     len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [P_W-1:0]       in_p,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic                 out_sat,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                 state, state_nxt;
  logic [CNT_W-1:0]       len_q, count, len_clamped;
  logic [ACC_WIDTH-1:0]   acc, p_ext, acc_sat;
  logic [ACC_WIDTH:0]     sum_w;
  logic                   ovf, beat, last;

  assign len_clamped = (len > CNT_W'(MAX_LEN)) ? CNT_W'(MAX_LEN) : len;
  assign beat        = in_valid && (state == ACCUM);
  assign last        = (count == len_q - CNT_W'(1));
  assign out_sum     = acc;

  // Widen the product to accumulator width, sign- or zero-extending by mode.
  always_comb begin
    p_ext = '0;
    if (SIGNED_MULT != 0) p_ext = ACC_WIDTH'($signed(in_p));
    else                  p_ext = ACC_WIDTH'(in_p);
  end

  // One-bit-wider add, then clamp to the representable rail on overflow.
  always_comb begin
    sum_w   = '0;
    acc_sat = '0;
    ovf     = 1'b0;
    if (SIGNED_MULT != 0) begin
      sum_w = {acc[ACC_WIDTH-1], acc} + {p_ext[ACC_WIDTH-1], p_ext};
      ovf   = sum_w[ACC_WIDTH] ^ sum_w[ACC_WIDTH-1];
      if (ovf) acc_sat = sum_w[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                          : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      else     acc_sat = sum_w[ACC_WIDTH-1:0];
    end else begin
      sum_w   = {1'b0, acc} + {1'b0, p_ext};
      ovf     = sum_w[ACC_WIDTH];
      acc_sat = ovf ? '1 : sum_w[ACC_WIDTH-1:0];
    end
  end

  // Next-state and handshake outputs; outputs depend on state only.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len == '0) ? DONE : ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (beat && last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, accumulator, beat counter and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      count   <= '0;
      len_q   <= '0;
      out_sat <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            acc     <= '0;
            count   <= '0;
            out_sat <= 1'b0;
            len_q   <= len_clamped;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc   <= acc_sat;
            count <= count + CNT_W'(1);
            if (ovf) out_sat <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_accumulator.sv
// Bench for mult_accumulator: an unsigned and a signed instance run in lockstep
// on shared stimulus; a scoreboard queue holds expected results computed by a
// plain-arithmetic model, and a negedge monitor compares whenever out_valid.
module tb_mult_accumulator;
  localparam int DW = 8;
  localparam int PW = 2*DW;
  localparam int AW = 17;
  localparam int ML = 16;
  localparam int CW = $clog2(ML+1);
  localparam longint UMAX = (longint'(1) << AW) - 1;
  localparam longint SMAX = (longint'(1) << (AW-1)) - 1;
  localparam longint SMIN = -(longint'(1) << (AW-1));

  typedef struct {
    logic [AW-1:0] us;
    logic          us_sat;
    logic [AW-1:0] ss;
    logic          ss_sat;
  } exp_t;

  logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
  logic [CW-1:0] len = '0;
  logic [PW-1:0] in_p = '0;
  logic u_in_ready, u_out_valid, u_out_sat, u_busy;
  logic s_in_ready, s_out_valid, s_out_sat, s_busy;
  logic [AW-1:0] u_out_sum, s_out_sum;

  int checks = 0, errors = 0;
  int mode = 0;  // 0: out_ready random, 1: stimulus owns out_ready
  exp_t exp_q[$];
  logic [PW-1:0] prod_q[$];

  always #5 clk = ~clk;

  mult_accumulator #(.DATA_WIDTH(DW), .SIGNED_MULT(0), .ACC_WIDTH(AW), .MAX_LEN(ML)) u_dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(u_in_ready), .in_p(in_p), .out_valid(u_out_valid), .out_ready(out_ready),
    .out_sum(u_out_sum), .out_sat(u_out_sat), .busy(u_busy));

  mult_accumulator #(.DATA_WIDTH(DW), .SIGNED_MULT(1), .ACC_WIDTH(AW), .MAX_LEN(ML)) s_dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid),
    .in_ready(s_in_ready), .in_p(in_p), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_sum(s_out_sum), .out_sat(s_out_sat), .busy(s_busy));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: running sum clamped to the rail after every product.
  function automatic exp_t model();
    exp_t e;
    longint ua = 0, sa = 0;
    e.us_sat = 1'b0;
    e.ss_sat = 1'b0;
    foreach (prod_q[k]) begin
      ua += longint'(prod_q[k]);
      if (ua > UMAX) begin ua = UMAX; e.us_sat = 1'b1; end
      sa += longint'($signed(prod_q[k]));
      if (sa > SMAX) begin sa = SMAX; e.ss_sat = 1'b1; end
      if (sa < SMIN) begin sa = SMIN; e.ss_sat = 1'b1; end
    end
    e.us = ua[AW-1:0];
    e.ss = sa[AW-1:0];
    return e;
  endfunction

  function automatic int eff_len(input int l);
    return (l > ML) ? ML : l;
  endfunction

  task automatic fill_rand(input int n);
    prod_q.delete();
    for (int k = 0; k < n; k++) prod_q.push_back(PW'($urandom));
  endtask

  task automatic wait_idle();
    int i = 0;
    while ((u_busy || s_busy) && i < 300) begin @(posedge clk); #1; i++; end
    chk("idle_timeout", {31'd0, u_busy | s_busy}, 32'd0);
  endtask

  // Issue one job from prod_q; optionally stall the result and poke start in DONE.
  task automatic run_job(input int len_in, input int gap_max, input bit hold);
    int n = eff_len(len_in);
    int tries;
    exp_q.push_back(model());
    if (hold) begin mode = 1; out_ready = 1'b0; end
    start = 1'b1; len = CW'(len_in);
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_busy", {31'd0, u_busy}, 32'd1);
    for (int k = 0; k < n; k++) begin
      int g = $urandom_range(0, gap_max);
      repeat (g) begin in_valid = 1'b0; in_p = PW'($urandom); @(posedge clk); #1; end
      in_valid = 1'b1; in_p = prod_q[k];
      tries = 0;
      while (!u_in_ready && tries < 20) begin @(posedge clk); #1; tries++; end
      chk("beat_ready", {31'd0, u_in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_p = PW'($urandom);
    chk("latency_u_valid", {31'd0, u_out_valid}, 32'd1);
    chk("latency_s_valid", {31'd0, s_out_valid}, 32'd1);
    chk("done_no_ready", {31'd0, u_in_ready | s_in_ready}, 32'd0);
    if (hold) begin
      repeat (5) begin
        start = 1'b1; len = CW'(3);
        @(posedge clk); #1;
        chk("hold_valid", {31'd0, u_out_valid}, 32'd1);
        chk("hold_no_ready", {31'd0, u_in_ready}, 32'd0);
      end
      start = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_hs_busy", {31'd0, u_busy | s_busy}, 32'd0);
      chk("idle_after_hs_valid", {31'd0, u_out_valid | s_out_valid}, 32'd0);
      out_ready = 1'b0;
      mode = 0;
    end
    wait_idle();
  endtask

  // Random result backpressure when the stimulus is not steering it.
  always begin
    @(posedge clk); #2;
    if (mode == 0) out_ready = 1'($urandom_range(0, 1));
  end

  // Scoreboard monitor: every valid cycle matches the head entry; pop on handshake.
  always @(negedge clk) begin
    if (!rst && (u_out_valid || s_out_valid)) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result actual=%0h expected=none", u_out_sum);
      end else begin
        chk("u_sum", 32'(u_out_sum), 32'(exp_q[0].us));
        chk("u_sat", {31'd0, u_out_sat}, {31'd0, exp_q[0].us_sat});
        chk("s_sum", 32'(s_out_sum), 32'(exp_q[0].ss));
        chk("s_sat", {31'd0, s_out_sat}, {31'd0, exp_q[0].ss_sat});
        chk("s_valid", {31'd0, s_out_valid}, 32'd1);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    int i;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", {31'd0, u_busy | s_busy}, 32'd0);
    chk("rst_in_ready", {31'd0, u_in_ready | s_in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, u_out_valid | s_out_valid}, 32'd0);
    chk("rst_sum", 32'(u_out_sum | s_out_sum), 32'd0);
    chk("rst_sat", {31'd0, u_out_sat | s_out_sat}, 32'd0);

    // Directed: 4 x 150, back-to-back.
    prod_q = '{16'd150, 16'd150, 16'd150, 16'd150};
    run_job(4, 0, 1'b0);
    // Signed mix -70, 70, -100.
    prod_q = '{16'hFFBA, 16'd70, 16'hFF9C};
    run_job(3, 0, 1'b0);
    // Large unsigned products: unsigned instance hits the top rail.
    prod_q = '{16'd65025, 16'd65025, 16'd65025};
    run_job(3, 0, 1'b0);
    // Repeated -16384: signed instance hits the bottom rail.
    prod_q = '{16'hC000, 16'hC000, 16'hC000, 16'hC000, 16'hC000};
    run_job(5, 0, 1'b0);
    // Off the rail again: saturate high, then a negative product pulls it back.
    prod_q = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000};
    run_job(4, 1, 1'b0);
    // Zero-length job.
    prod_q.delete();
    run_job(0, 0, 1'b0);
    // Gaps between beats, then a stalled result with ignored start pulses.
    prod_q = '{16'd1234, 16'd4321};
    run_job(2, 3, 1'b1);
    // Length beyond MAX_LEN clamps.
    fill_rand(ML);
    run_job(ML + 4, 1, 1'b0);

    // Reset in the middle of a job: no result, everything cleared.
    prod_q = '{16'd500, 16'd600};
    start = 1'b1; len = CW'(4);
    @(posedge clk); #1;
    start = 1'b0;
    foreach (prod_q[k]) begin in_valid = 1'b1; in_p = prod_q[k]; @(posedge clk); #1; end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", {31'd0, u_busy | s_busy}, 32'd0);
    chk("midrst_in_ready", {31'd0, u_in_ready | s_in_ready}, 32'd0);
    chk("midrst_out_valid", {31'd0, u_out_valid | s_out_valid}, 32'd0);
    chk("midrst_sum", 32'(u_out_sum | s_out_sum), 32'd0);
    prod_q = '{16'd25};
    run_job(1, 0, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 25; j++) begin
      int l = $urandom_range(0, ML + 4);
      fill_rand(eff_len(l));
      run_job(l, 2, 1'b0);
    end

    i = 0;
    while (exp_q.size() != 0 && i < 50) begin @(posedge clk); i++; end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
